alu_result_stage: RTL and testbench

- Pipeline stage directly downstream of the ALU.
- Captures the ALU result, the `alu_flags_t` flags and the destination info into a 2-entry skid buffer with a valid/ready handshake toward writeback.
- Holds the architectural flag register, updated in order when a flag-setting op commits to writeback.
- Decouples ALU timing from writeback back-pressure without a combinational ready path.

---
 rtl/alu_result_stage.sv | 139 +++++++++++++
 tb/tb_alu_result_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result capture into a 2-entry skid buffer plus architectural flag register
// Optional stall counter output enabled by defining ALU_RESULT_STALL_CNT_EN.
module alu_result_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [DATA_W-1:0]     ex_result_i,
  input  logic [3:0]            ex_flags_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_wen_i,
  input  logic                  ex_setflags_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [DATA_W-1:0]     wb_result_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic                  wb_wen_o,
  output logic [3:0]            flags_o
`ifdef ALU_RESULT_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  logic                  main_valid;
  logic [DATA_W-1:0]     main_result;
  logic [3:0]            main_flags;
  logic [REG_ADDR_W-1:0] main_rd;
  logic                  main_wen;
  logic                  main_setflags;

  logic                  skid_valid;
  logic [DATA_W-1:0]     skid_result;
  logic [3:0]            skid_flags;
  logic [REG_ADDR_W-1:0] skid_rd;
  logic                  skid_wen;
  logic                  skid_setflags;

  logic                  flags_q;
  logic [3:0]            arch_flags;

  logic accept;
  logic transfer;
  logic main_free;
  logic skid_valid_nxt;

  assign accept    = ex_valid_i & ex_ready_o;
  assign transfer  = main_valid & wb_ready_i;
  assign main_free = ~main_valid | transfer;

  // Skid only fills when main is occupied and not draining; any drain of main empties it.
  always_comb begin
    skid_valid_nxt = 1'b0;
    if (!flush_i && !main_free)
      skid_valid_nxt = skid_valid | accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid    <= 1'b0;
      main_result   <= '0;
      main_flags    <= '0;
      main_rd       <= '0;
      main_wen      <= 1'b0;
      main_setflags <= 1'b0;
      skid_valid    <= 1'b0;
      skid_result   <= '0;
      skid_flags    <= '0;
      skid_rd       <= '0;
      skid_wen      <= 1'b0;
      skid_setflags <= 1'b0;
      ex_ready_o    <= 1'b1;
      arch_flags    <= '0;
      flags_q       <= 1'b0;
    end else begin
      if (flush_i) begin
        main_valid <= 1'b0;
      end else if (main_free) begin
        if (skid_valid) begin
          main_valid    <= 1'b1;
          main_result   <= skid_result;
          main_flags    <= skid_flags;
          main_rd       <= skid_rd;
          main_wen      <= skid_wen;
          main_setflags <= skid_setflags;
        end else if (accept) begin
          main_valid    <= 1'b1;
          main_result   <= ex_result_i;
          main_flags    <= ex_flags_i;
          main_rd       <= ex_rd_i;
          main_wen      <= ex_wen_i;
          main_setflags <= ex_setflags_i;
        end else begin
          main_valid <= 1'b0;
        end
      end

      if (!flush_i && !main_free && accept) begin
        skid_result   <= ex_result_i;
        skid_flags    <= ex_flags_i;
        skid_rd       <= ex_rd_i;
        skid_wen      <= ex_wen_i;
        skid_setflags <= ex_setflags_i;
      end

      skid_valid <= skid_valid_nxt;
      ex_ready_o <= ~skid_valid_nxt;

      // Writeback has sampled the entry, so flags commit even in a flush cycle.
      if (transfer && main_setflags) begin
        arch_flags <= main_flags;
        flags_q    <= 1'b1;
      end
    end
  end

  assign wb_valid_o  = main_valid;
  assign wb_result_o = main_result;
  assign wb_rd_o     = main_rd;
  assign wb_wen_o    = main_wen;
  assign flags_o     = arch_flags;

  logic unused_ok;
  assign unused_ok = flags_q;

`ifdef ALU_RESULT_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_o <= '0;
    else if (main_valid && !wb_ready_i && stall_cnt_o != 32'hFFFF_FFFF)
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_result_i;
  logic [3:0]  ex_flags_i;
  logic [4:0]  ex_rd_i;
  logic        ex_wen_i;
  logic        ex_setflags_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_rd_o;
  logic        wb_wen_o;
  logic [3:0]  flags_o;
`ifdef ALU_RESULT_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  alu_result_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .ex_result_i   (ex_result_i),
    .ex_flags_i    (ex_flags_i),
    .ex_rd_i       (ex_rd_i),
    .ex_wen_i      (ex_wen_i),
    .ex_setflags_i (ex_setflags_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_result_o   (wb_result_o),
    .wb_rd_o       (wb_rd_o),
    .wb_wen_o      (wb_wen_o),
    .flags_o       (flags_o)
`ifdef ALU_RESULT_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic [3:0] fl, input logic sf);
    ex_valid_i    = v;
    ex_result_i   = res;
    ex_rd_i       = rd;
    ex_flags_i    = fl;
    ex_setflags_i = sf;
    ex_wen_i      = 1'b1;
  endtask

  initial begin
    int sent;
    int recv;
    logic acc, pv, pr;
    logic [31:0] pres;
    logic [4:0]  prd;

    rst_n = 1'b0;
    flush_i = 1'b0;
    wb_ready_i = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 4'b0000, 1'b0);
    ex_wen_i = 1'b0;
    tick;
    tick;
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_ex_ready", 32'(ex_ready_o), 32'd1);
    chk("rst_flags", 32'(flags_o), 32'd0);
    chk("rst_result", wb_result_o, 32'd0);
    chk("rst_rd", 32'(wb_rd_o), 32'd0);
    chk("rst_wen", 32'(wb_wen_o), 32'd0);
    rst_n = 1'b1;
    tick;

    // Single op with writeback ready
    wb_ready_i = 1'b1;
    drive(1'b1, 32'h5, 5'd3, 4'b0000, 1'b1);
    tick;
    chk("single_valid", 32'(wb_valid_o), 32'd1);
    chk("single_result", wb_result_o, 32'h5);
    chk("single_rd", 32'(wb_rd_o), 32'd3);
    chk("single_wen", 32'(wb_wen_o), 32'd1);
    chk("single_flags_pre", 32'(flags_o), 32'd0);
    drive(1'b0, 32'h0, 5'd0, 4'b0000, 1'b0);
    tick;
    chk("single_drained", 32'(wb_valid_o), 32'd0);
    chk("single_flags_post", 32'(flags_o), 32'd0);

    // Back-pressure: A then B with writeback stalled
    wb_ready_i = 1'b0;
    drive(1'b1, 32'd1, 5'd1, 4'b0000, 1'b0);
    tick;
    chk("bp_a_valid", 32'(wb_valid_o), 32'd1);
    chk("bp_a_ready", 32'(ex_ready_o), 32'd1);
    drive(1'b1, 32'd2, 5'd2, 4'b0000, 1'b0);
    tick;
    chk("bp_skid_ready", 32'(ex_ready_o), 32'd0);
    chk("bp_hold_a", wb_result_o, 32'd1);
    drive(1'b0, 32'd0, 5'd0, 4'b0000, 1'b0);
    tick;
    chk("bp_still_a", wb_result_o, 32'd1);
    chk("bp_still_full", 32'(ex_ready_o), 32'd0);
    wb_ready_i = 1'b1;
    tick;
    chk("bp_b_valid", 32'(wb_valid_o), 32'd1);
    chk("bp_b_result", wb_result_o, 32'd2);
    chk("bp_b_rd", 32'(wb_rd_o), 32'd2);
    chk("bp_ready_back", 32'(ex_ready_o), 32'd1);
    tick;
    chk("bp_empty", 32'(wb_valid_o), 32'd0);

    // Flag ordering: A sets 1000, B (no setflags) carries 0100
    wb_ready_i = 1'b0;
    drive(1'b1, 32'd10, 5'd4, 4'b1000, 1'b1);
    tick;
    chk("fl_pre", 32'(flags_o), 32'd0);
    drive(1'b1, 32'd11, 5'd5, 4'b0100, 1'b0);
    tick;
    chk("fl_accept_noupd", 32'(flags_o), 32'd0);
    drive(1'b0, 32'd0, 5'd0, 4'b0000, 1'b0);
    wb_ready_i = 1'b1;
    tick;
    chk("fl_after_a", 32'(flags_o), 32'b1000);
    chk("fl_b_present", wb_result_o, 32'd11);
    tick;
    chk("fl_after_b", 32'(flags_o), 32'b1000);
    chk("fl_b_gone", 32'(wb_valid_o), 32'd0);

    // Flush with both entries held
    wb_ready_i = 1'b0;
    drive(1'b1, 32'd20, 5'd6, 4'b0011, 1'b1);
    tick;
    drive(1'b1, 32'd21, 5'd7, 4'b0001, 1'b1);
    tick;
    chk("fsh_full", 32'(ex_ready_o), 32'd0);
    flush_i = 1'b1;
    drive(1'b1, 32'd99, 5'd9, 4'b1111, 1'b1);
    tick;
    chk("fsh_valid", 32'(wb_valid_o), 32'd0);
    chk("fsh_ready", 32'(ex_ready_o), 32'd1);
    chk("fsh_flags", 32'(flags_o), 32'b1000);
    flush_i = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 4'b0000, 1'b0);
    tick;
    chk("fsh_dropped", 32'(wb_valid_o), 32'd0);

    // Accept coinciding with flush into an empty stage is dropped
    flush_i = 1'b1;
    drive(1'b1, 32'd77, 5'd8, 4'b0010, 1'b1);
    tick;
    flush_i = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 4'b0000, 1'b0);
    chk("fsh_acc_drop", 32'(wb_valid_o), 32'd0);

    // Transfer in a flush cycle still commits flags
    drive(1'b1, 32'd30, 5'd10, 4'b0011, 1'b1);
    tick;
    drive(1'b0, 32'd0, 5'd0, 4'b0000, 1'b0);
    wb_ready_i = 1'b1;
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    chk("fsh_xfer_flags", 32'(flags_o), 32'b0011);
    chk("fsh_xfer_valid", 32'(wb_valid_o), 32'd0);

    // Streaming 16 ops with random writeback readiness
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 400 && recv < 16; cyc++) begin
      drive(sent < 16, 32'(sent), 5'(sent), 4'b0000, 1'b0);
      wb_ready_i = 1'($urandom_range(0, 1));
      acc  = ex_valid_i && ex_ready_o;
      pv   = wb_valid_o;
      pr   = wb_ready_i;
      pres = wb_result_o;
      prd  = wb_rd_o;
      tick;
      if (acc) sent++;
      if (pv && pr) begin
        chk("stream_order", pres, 32'(recv));
        chk("stream_rd", 32'(prd), 32'(recv[4:0]));
        recv++;
      end else if (pv) begin
        chk("stream_stall_valid", 32'(wb_valid_o), 32'd1);
        chk("stream_stall_hold", wb_result_o, pres);
      end
    end
    drive(1'b0, 32'd0, 5'd0, 4'b0000, 1'b0);
    chk("stream_count", 32'(recv), 32'd16);
    chk("stream_flags", 32'(flags_o), 32'b0011);

    // Reset mid-operation loses entries and clears flags
    wb_ready_i = 1'b0;
    drive(1'b1, 32'd40, 5'd11, 4'b0101, 1'b1);
    tick;
    drive(1'b0, 32'd0, 5'd0, 4'b0000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(wb_valid_o), 32'd0);
    chk("mrst_flags", 32'(flags_o), 32'd0);
    chk("mrst_ready", 32'(ex_ready_o), 32'd1);
    tick;
    rst_n = 1'b1;

`ifdef ALU_RESULT_STALL_CNT_EN
    chk("scnt_rst", stall_cnt_o, 32'd0);
    drive(1'b1, 32'd50, 5'd12, 4'b0000, 1'b0);
    tick;
    drive(1'b0, 32'd0, 5'd0, 4'b0000, 1'b0);
    for (int i = 0; i < 7; i++) tick;
    chk("scnt_seven", stall_cnt_o, 32'd7);
    wb_ready_i = 1'b1;
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    chk("scnt_after_flush", stall_cnt_o, 32'd7);
    tick;
    chk("scnt_stays", stall_cnt_o, 32'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
